// File: rtl/serializer_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : serializer_frame_arbiter_if
// Brief   : Requester-side and serializer-side bus of the frame arbiter.
// Revision: 1.0
// ============================================================================
interface serializer_frame_arbiter_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  parameter int N_REQ     = 4
);
  localparam int CW = $clog2(N_REQ);

  logic [N_REQ*N_SAMPLES*BIT_WIDTH-1:0] req_msg;
  logic [N_REQ-1:0]                     req_val;
  logic [N_REQ-1:0]                     req_rdy;
  logic [N_SAMPLES*BIT_WIDTH-1:0]       ser_msg;
  logic                                 ser_val;
  logic                                 ser_rdy;
  logic                                 ser_out_fire;
  logic [CW-1:0]                        out_chan;
  logic                                 busy;

  // The arbiter is the slave of the requesters and drives the serializer side.
  modport slave (
    input  req_msg, req_val, ser_rdy, ser_out_fire,
    output req_rdy, ser_msg, ser_val, out_chan, busy
  );

  modport master (
    output req_msg, req_val, ser_rdy, ser_out_fire,
    input  req_rdy, ser_msg, ser_val, out_chan, busy
  );
endinterface
`default_nettype wire

// File: rtl/serializer_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : serializer_frame_arbiter
// Brief   : Round-robin sharing of one parallel-to-serial serializer by N_REQ
//           frame producers; next grant waits until the frame has drained.
// Revision: 1.0
// ============================================================================
module serializer_frame_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  parameter int N_REQ     = 4
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  serializer_frame_arbiter_if.slave    bus
);

  localparam int CW   = $clog2(N_REQ);
  localparam int CNTW = $clog2(N_SAMPLES);
  localparam int FW   = N_SAMPLES * BIT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [FW-1:0]   frame_q, frame_d;

  logic [FW-1:0]    req_frame [N_REQ];
  logic [CW-1:0]    win_idx;
  logic             win_found;
  logic [CW-1:0]    chan_next;
  logic [N_REQ-1:0] req_rdy_w;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
    assign req_frame[gi] = bus.req_msg[gi*FW +: FW];
  end

  // Scan offsets from high to low so the requester closest to rr_ptr wins.
  always_comb begin : arb_search
    logic [CW:0]   sum;
    logic [CW-1:0] idx;
    sum       = '0;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (sum >= (CW+1)'(N_REQ)) begin
        sum = sum - (CW+1)'(N_REQ);
      end
      idx = sum[CW-1:0];
      if (bus.req_val[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign chan_next = (chan_q == CW'(N_REQ - 1)) ? '0 : chan_q + CW'(1);

  always_comb begin : fsm_next
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    chan_d    = chan_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    req_rdy_w = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_rdy_w[win_idx] = 1'b1;
          frame_d            = req_frame[win_idx];
          chan_d             = win_idx;
          state_d            = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.ser_rdy) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (bus.ser_out_fire) begin
          if (cnt_q == CNTW'(N_SAMPLES - 1)) begin
            state_d  = ST_IDLE;
            rr_ptr_d = chan_next;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : fsm_regs
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      chan_q   <= '0;
      cnt_q    <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      chan_q   <= chan_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
    end
  end

  // State is already IDLE under reset, so the grant path is masked explicitly.
  assign bus.req_rdy  = reset ? '0 : req_rdy_w;
  assign bus.ser_val  = (state_q == ST_ISSUE);
  assign bus.ser_msg  = frame_q;
  assign bus.out_chan = chan_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/serializer_frame_arbiter.md
Name: serializer_frame_arbiter

Overview:
- Shares one parallel-to-serial serializer between N_REQ frame producers, e.g. several sample sources feeding one SERDES lane.
- Round-robin arbitration picks one producer. Its whole frame of N_SAMPLES words is latched into a local register and issued to the serializer with a val/rdy handshake.
- The serial words leaving the serializer are counted, and the next grant is blocked until all N_SAMPLES words have drained.
- Outputs a channel tag so downstream logic can demultiplex the serial stream.

Parameters:
- BIT_WIDTH, 32, width of one sample word.
- N_SAMPLES, 8, words per frame; must be >= 2.
- N_REQ, 4, number of requesters; must be >= 2.
- CW, $clog2(N_REQ), channel tag width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_msg  input  N_REQ*N_SAMPLES*BIT_WIDTH  flat frames; requester i occupies bits [(i+1)*N_SAMPLES*BIT_WIDTH-1 : i*N_SAMPLES*BIT_WIDTH]; sample j of a frame sits at word offset j.
- req_val  input  N_REQ  per-requester frame valid.
- req_rdy  output  N_REQ  per-requester ready; at most one bit high per cycle.
- ser_msg  output  N_SAMPLES*BIT_WIDTH  latched frame to the serializer's parallel input, same word order.
- ser_val  output  1  frame valid to the serializer.
- ser_rdy  input  1  serializer ready.
- ser_out_fire  input  1  pulses when one serial word leaves the serializer (its send_val & send_rdy).
- out_chan  output  CW  requester index owning the current frame.
- busy  output  1  high in ISSUE or DRAIN.

Behaviour:
- Reset (async assert, sync-style release):
  - State IDLE, rr_ptr=0, cnt=0, frame register=0, chan register=0.
  - Outputs: req_rdy=0, ser_val=0, ser_msg=0, out_chan=0, busy=0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - Winner = first i with req_val[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_rdy[winner]=1 combinationally; all other bits 0. If no req_val bit is set, req_rdy=0 and the FSM stays in IDLE.
  - When a winner exists, its frame is captured into the frame register, the chan register takes the winner index, and the FSM goes to ISSUE next cycle.
  - The handshake completes in this cycle because req_rdy is asserted only for a valid winner.
- ISSUE:
  - ser_val=1; ser_msg = frame register, held stable.
  - ser_rdy=1 -> DRAIN, cnt=0. ser_rdy=0 -> stay in ISSUE.
- DRAIN:
  - ser_val=0; each ser_out_fire increments cnt.
  - ser_out_fire with cnt==N_SAMPLES-1 -> IDLE, rr_ptr = (chan+1) mod N_REQ, cnt=0.
- ser_out_fire is ignored outside DRAIN. A fire in the same cycle as the ISSUE->DRAIN transition is not counted; the serializer cannot emit a word in the cycle it accepts a frame.
- req_rdy is 0 in ISSUE and DRAIN. Requesters must hold req_val and req_msg until their handshake; a dropped req_val before grant is legal and simply loses priority.
- out_chan = chan register, valid while busy=1; it holds its last value otherwise.
- Throughput: one idle cycle between frames. Best-case frame period = 1 (IDLE) + 1 (ISSUE) + N_SAMPLES drain cycles.
- Fairness: a requester holding req_val continuously is granted within N_REQ frames.
- rr_ptr wraps from N_REQ-1 to 0. Non-power-of-two N_REQ must wrap correctly, never reaching an index >= N_REQ.
- A reset asserted in any state aborts the current frame immediately. No req_rdy or ser_val glitch is allowed after reset asserts; the partially drained frame is not replayed.
- The frame register is written only on an IDLE handshake; ser_msg must not change during ISSUE.

Test Plan:
- Single requester: N_REQ=4, N_SAMPLES=8; req_val=4'b0100 with frame words 0x10..0x17. Required: req_rdy=4'b0100 for 1 cycle; ser_val next cycle carrying those words; out_chan=2; after 8 ser_out_fire pulses back to IDLE with rr_ptr=3.
- Round-robin: req_val=4'b1111 held, ser_rdy=1, ser_out_fire high in every DRAIN cycle. Required: grant order 0,1,2,3,0; each frame period exactly 10 cycles.
- Serializer backpressure: ser_rdy=0 for 5 cycles in ISSUE. Required: ser_val stays 1, ser_msg unchanged, req_rdy=0; DRAIN entered on the cycle after ser_rdy rises.
- Drain counting: 7 fires, then 3 idle cycles, then the 8th fire. Required: busy stays 1 until the 8th fire, then IDLE; fires injected in IDLE must not change cnt.
- Reset mid-DRAIN after 3 fires. Required: outputs reach reset values asynchronously; after release with req_val=4'b0001, requester 0 is granted and the next drain needs a full 8 fires.
- Non-power-of-two wrap: N_REQ=3, req_val=3'b111. Required: grants 0,1,2,0 and out_chan never equals 3.
